// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_pkg : shared SPI types and constants (state enum, Mode-0 polarities)   |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
package spi_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    // Mode 0: serial clock idles low; chip select is active low, idles high
    localparam logic SPI_CPOL    = 1'b0;
    localparam logic SPI_CS_IDLE = 1'b1;

    function automatic int spi_cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_sync_edge : 2-flop synchronizer with history flop and edge detection   |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_hist <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_hist;
    assign o_fall = ~r_sync & r_hist;

endmodule
`default_nettype wire

// File: rtl/spi_slave_m_bit_rw.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_slave_m_bit_rw : oversampled Mode-0 SPI responder with tx buffer       |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module spi_slave_m_bit_rw
    import spi_pkg::*;
#(
    parameter  int REG_WIDTH = 8,
    localparam int CW        = spi_cnt_width(REG_WIDTH)
) (
    input  logic                 sys_clk,
    input  logic                 rstn,
    input  logic [REG_WIDTH-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [REG_WIDTH-1:0] rx_data,
    output logic [CW:0]          rx_bits,
    output logic                 rx_valid,
    output logic                 tx_underrun,
    output logic                 busy,
    input  logic                 spi_clk,
    input  logic                 cs,
    input  logic                 mosi,
    output logic                 miso
);

    localparam logic [CW:0] c_FULL_CNT = (CW+1)'(REG_WIDTH);
    localparam logic [CW:0] c_ONE      = (CW+1)'(1);

    spi_state_e           r_state;
    spi_state_e           w_state_nxt;
    logic                 w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic                 r_mosi_meta, r_mosi_sync;
    logic [REG_WIDTH-1:0] r_rx_shift, r_tx_shift, r_tx_buf, w_rx_next;
    logic [CW:0]          r_cnt, w_cnt_next;
    logic                 r_buf_full, r_und_pend;
    logic                 w_word_start, w_word_done, w_partial, w_handshake;
    logic [REG_WIDTH-1:0] r_rx_data;
    logic [CW:0]          r_rx_bits;
    logic                 r_rx_valid, r_underrun;

    spi_sync_edge #(.RESET_VAL(SPI_CPOL)) u_sclk_sync (
        .clk(sys_clk), .rstn(rstn), .i_d(spi_clk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(SPI_CS_IDLE)) u_cs_sync (
        .clk(sys_clk), .rstn(rstn), .i_d(cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // A spi_clk rise coinciding with cs rise is folded in before the cs rule
    always_comb begin
        w_state_nxt  = r_state;
        w_word_start = 1'b0;
        w_word_done  = 1'b0;
        w_partial    = 1'b0;
        w_cnt_next   = w_sclk_rise ? r_cnt + c_ONE : r_cnt;
        w_rx_next    = w_sclk_rise ? {r_rx_shift[REG_WIDTH-2:0], r_mosi_sync} : r_rx_shift;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt  = ACTIVE;
                    w_word_start = 1'b1;
                end
            end
            ACTIVE: begin
                w_word_done = w_sclk_rise && (w_cnt_next == c_FULL_CNT);
                if (w_cs_rise) begin
                    w_state_nxt = IDLE;
                    w_partial   = !w_word_done && (w_cnt_next != '0);
                end else begin
                    w_word_start = w_word_done;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_handshake = tx_valid & ~r_buf_full;

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_cnt      <= '0;
            r_tx_buf   <= '0;
            r_buf_full <= 1'b0;
            r_und_pend <= 1'b0;
            r_rx_data  <= '0;
            r_rx_bits  <= '0;
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_rx_valid <= w_word_done | w_partial;
            r_underrun <= 1'b0;
            if (w_word_done | w_partial) begin
                r_rx_data <= w_rx_next;
                r_rx_bits <= w_cnt_next;
            end

            // Underrun is reported on the word's first spi_clk rise, so a word
            // start that is never clocked (end of frame) raises no strobe.
            if (w_word_start) begin
                r_tx_shift <= r_buf_full ? r_tx_buf : '0;
                r_und_pend <= ~r_buf_full;
                r_rx_shift <= '0;
                r_cnt      <= '0;
            end else if (r_state == ACTIVE) begin
                if (w_sclk_rise) begin
                    r_rx_shift <= w_rx_next;
                    r_cnt      <= w_cnt_next;
                    r_underrun <= r_und_pend;
                    r_und_pend <= 1'b0;
                end
                // The fall trailing the last rise of a word must not shift the reloaded word
                if (w_sclk_fall && (r_cnt != '0)) begin
                    r_tx_shift <= {r_tx_shift[REG_WIDTH-2:0], 1'b0};
                end
            end

            if (w_handshake) begin
                r_tx_buf   <= tx_data;
                r_buf_full <= 1'b1;
            end else if (w_word_start) begin
                r_buf_full <= 1'b0;
            end
        end
    end

    assign tx_ready    = ~r_buf_full;
    assign rx_data     = r_rx_data;
    assign rx_bits     = r_rx_bits;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_underrun;
    assign busy        = (r_state == ACTIVE);
    assign miso        = cs ? 1'bz : r_tx_shift[REG_WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_m_bit_rw.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_slave_m_bit_rw : directed SPI master stimulus with rx scoreboard     |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_spi_slave_m_bit_rw;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic          sys_clk  = 1'b0;
    logic          rstn     = 1'b0;
    logic [W-1:0]  tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [W-1:0]  rx_data;
    logic [CW:0]   rx_bits;
    logic          rx_valid;
    logic          tx_underrun;
    logic          busy;
    logic          spi_clk  = 1'b0;
    logic          cs       = 1'b1;
    logic          mosi     = 1'b0;
    wire           miso;

    int checks   = 0;
    int failures = 0;
    int n_strobe = 0;
    int n_und    = 0;
    int s0, u0;

    logic [W+CW:0] exp_q[$];
    logic          prev_valid = 1'b0;

    spi_slave_m_bit_rw #(.REG_WIDTH(W)) dut (
        .sys_clk(sys_clk), .rstn(rstn),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_bits(rx_bits), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .busy(busy),
        .spi_clk(spi_clk), .cs(cs), .mosi(mosi), .miso(miso)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Master sends the top nbits of data MSB first; the slave right-aligns them
    task automatic push_exp(input logic [W-1:0] data, input int nbits);
        logic [W-1:0] d;
        d = data >> (W - nbits);
        exp_q.push_back({(CW+1)'(nbits), d});
    endtask

    always @(negedge sys_clk) begin
        if (rx_valid) begin
            n_strobe++;
            chk("rx_valid_not_back_to_back", {31'b0, prev_valid}, 32'd0);
            chk("rx_strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                logic [W+CW:0] e;
                e = exp_q.pop_front();
                chk("rx_data", 32'(rx_data), 32'(e[W-1:0]));
                chk("rx_bits", 32'(rx_bits), 32'(e[W+CW:W]));
            end
        end
        if (tx_underrun) n_und++;
        prev_valid = rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic handshake(input logic [W-1:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        chk("tx_ready_after_load", 32'(tx_ready), 32'd0);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        tick(4);
        chk("busy_after_cs_fall", 32'(busy), 32'd1);
        chk("tx_ready_after_consume", 32'(tx_ready), 32'd1);
    endtask

    // sys_clk/4 serial clock; miso is sampled at the end of each high phase
    task automatic xfer(input logic [W-1:0] data, input int nbits, input logic [W-1:0] exp_miso);
        for (int i = 0; i < nbits; i++) begin
            mosi = data[W-1-i];
            tick(2);
            spi_clk = 1'b1;
            tick(2);
            chk($sformatf("miso_bit%0d", i), 32'(miso), 32'(exp_miso[W-1-i]));
            spi_clk = 1'b0;
        end
    endtask

    task automatic cs_high();
        tick(2);
        cs   = 1'b1;
        mosi = 1'b0;
        tick(8);
        chk("busy_after_cs_rise", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_rx_bits", 32'(rx_bits), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_tx_underrun", 32'(tx_underrun), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_tx_ready", 32'(tx_ready), 32'd1);
        rstn = 1'b1;
        tick(2);

        // Full word
        s0 = n_strobe; u0 = n_und;
        handshake(8'hA5);
        push_exp(8'h3C, 8);
        cs_low();
        xfer(8'h3C, 8, 8'hA5);
        cs_high();
        chk("full_strobe_count", 32'(n_strobe - s0), 32'd1);
        chk("full_no_underrun", 32'(n_und - u0), 32'd0);
        chk("full_rx_data_literal", 32'(rx_data), 32'h3C);
        chk("full_rx_bits_literal", 32'(rx_bits), 32'd8);
        chk("full_tx_ready", 32'(tx_ready), 32'd1);

        // Partial frame
        s0 = n_strobe;
        handshake(8'h6B);
        push_exp(8'hE0, 3);
        cs_low();
        xfer(8'hE0, 3, 8'h6B);
        cs_high();
        chk("partial_strobe_count", 32'(n_strobe - s0), 32'd1);
        chk("partial_rx_data_literal", 32'(rx_data), 32'h07);
        chk("partial_rx_bits_literal", 32'(rx_bits), 32'd3);

        // Back-to-back words under one cs
        s0 = n_strobe; u0 = n_und;
        handshake(8'h9C);
        push_exp(8'h12, 8);
        push_exp(8'h34, 8);
        cs_low();
        handshake(8'h56);
        xfer(8'h12, 8, 8'h9C);
        xfer(8'h34, 8, 8'h56);
        cs_high();
        chk("b2b_strobe_count", 32'(n_strobe - s0), 32'd2);
        chk("b2b_no_underrun", 32'(n_und - u0), 32'd0);
        chk("b2b_rx_data_literal", 32'(rx_data), 32'h34);

        // Underrun
        s0 = n_strobe; u0 = n_und;
        push_exp(8'h5A, 8);
        cs_low();
        xfer(8'h5A, 8, 8'h00);
        cs_high();
        chk("underrun_pulse_count", 32'(n_und - u0), 32'd1);
        chk("underrun_strobe_count", 32'(n_strobe - s0), 32'd1);

        // Reset mid-frame
        s0 = n_strobe;
        handshake(8'hC3);
        cs_low();
        xfer(8'hA0, 4, 8'hC3);
        rstn    = 1'b0;
        cs      = 1'b1;
        spi_clk = 1'b0;
        mosi    = 1'b0;
        tick(3);
        chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
        chk("midrst_rx_data", 32'(rx_data), 32'd0);
        chk("midrst_rx_bits", 32'(rx_bits), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
        chk("midrst_tx_underrun", 32'(tx_underrun), 32'd0);
        rstn = 1'b1;
        tick(6);
        chk("midrst_no_strobe", 32'(n_strobe - s0), 32'd0);
        handshake(8'h81);
        push_exp(8'hFF, 8);
        cs_low();
        xfer(8'hFF, 8, 8'h81);
        cs_high();
        chk("post_reset_rx_data_literal", 32'(rx_data), 32'hFF);

        // spi_clk toggling with cs high is ignored
        s0 = n_strobe;
        for (int i = 0; i < 8; i++) begin
            mosi    = 1'b1;
            spi_clk = 1'b1;
            tick(2);
            chk("idle_busy", 32'(busy), 32'd0);
            spi_clk = 1'b0;
            tick(2);
        end
        tick(6);
        chk("idle_no_strobe", 32'(n_strobe - s0), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_m_bit_rw.md
Name: spi_slave_m_bit_rw

Overview:
- SPI responder (slave) for the team's m-bit SPI master. Mode 0 (CPOL=0, CPHA=0), MSB first, chip select active low.
- Runs entirely in the sys_clk domain. spi_clk, cs and mosi are oversampled through 2-flop synchronizers; edges are detected digitally.
- System side gets one transmit word buffer with a valid/ready handshake and a single-cycle receive strobe that reports the number of bits received.
- Partial frames shorter than reg_width are supported, matching the master's t_size transfers.

Parameters:
- reg_width, 8, shift register / word width in bits (≥2).
- counter_width, $clog2(reg_width), derived; bit counters are counter_width+1 bits wide.

Ports:
- sys_clk  input  1  system clock; the only clock.
- rstn  input  1  synchronous active-low reset, sampled on posedge sys_clk.
- tx_data  input  reg_width  word to return on miso in the next frame/word.
- tx_valid  input  1  tx_data valid; transfer occurs when tx_valid && tx_ready.
- tx_ready  output  1  transmit buffer empty.
- rx_data  output  reg_width  last received word, right-aligned.
- rx_bits  output  counter_width+1  number of valid bits in rx_data (1..reg_width).
- rx_valid  output  1  one-cycle strobe: rx_data/rx_bits updated.
- tx_underrun  output  1  one-cycle strobe: word started with an empty buffer.
- busy  output  1  high while a frame is active (synchronized cs low).
- spi_clk  input  1  serial clock from master.
- cs  input  1  chip select, active low.
- mosi  input  1  master-out data.
- miso  output  1  slave-out data; 1'bz when raw cs is high.

Behaviour:
- Reset (rstn=0 at posedge):
  - rx_data=0, rx_bits=0, rx_valid=0, tx_underrun=0, busy=0, tx_ready=1.
  - Shift registers and bit counter cleared; state=IDLE.
  - Synchronizer flops reset to spi_clk=0, cs=1, mosi=0.
  - Reset mid-frame aborts the frame without an rx_valid.
- Synchronization: 2 flops per input plus one history flop for spi_clk and cs. rise/fall are detected when sync != history.
- Timing requirement: spi_clk frequency ≤ sys_clk/4, and cs setup/hold ≥ 2 sys_clk around the first and last spi_clk edge.
- Transmit buffer:
  - tx_ready=1 when empty; a handshake stores tx_data and drops tx_ready next cycle.
  - A word start consumes the buffer, and tx_ready returns to 1 next cycle.
  - A handshake in the same cycle as a consume is accepted for the following word.
- FSM states: IDLE, ACTIVE.
  - IDLE: busy=0. On cs fall → ACTIVE. Word start: tx shift register = buffer if full, else all zeros with tx_underrun pulsed; bit counter=0.
  - ACTIVE: busy=1.
    - spi_clk rise: rx shift register ← {rx[reg_width-2:0], mosi_sync}; bit counter+1.
    - spi_clk fall: tx shift register shifts left, zero-filled.
    - When the counter reaches reg_width (detected in the rise cycle): next cycle rx_data=rx shift register, rx_bits=reg_width, rx_valid=1. Counter returns to 0 and a new word start occurs, so back-to-back words are supported without cs deassertion.
    - cs rise: if counter in 1..reg_width-1, next cycle rx_data = partial bits right-aligned (upper bits 0), rx_bits=counter, rx_valid=1. If counter=0, no strobe. → IDLE.
    - cs rise and a spi_clk rise in the same cycle: the rise is processed first, then the cs rule applies.
- miso = tx_shift[reg_width-1] while raw cs=0, otherwise 1'bz. The first bit is valid ≤3 sys_clk after cs falls.
- rx_data and rx_bits hold between strobes. rx_valid never asserts for two consecutive cycles.

Decomposition:
- Package spi_pkg: state enum (IDLE, ACTIVE), Mode-0 polarity constants, a counter_width helper function. Shared with the master going forward.
- One sub-module: spi_sync_edge, a 2-flop synchronizer plus edge detector. It is instantiated for spi_clk (rise/fall) and cs (fall/rise). mosi uses the synchronizer only.

Test Plan:
- Full word: preload tx 8'hA5; master sends 8'h3C with t_size=8 at sys_clk/4 → miso stream 1,0,1,0,0,1,0,1; rx_valid once with rx_data=8'h3C, rx_bits=8; tx_ready returns to 1.
- Partial frame: master t_size=3 sending 8'hE0 (bits 1,1,1) → rx_data=8'h07, rx_bits=3; cs rise strobes rx_valid exactly once.
- Back-to-back: cs held low for 16 clocks with 8'h12 then 8'h34; tx buffer refilled with 8'h56 after the first consume → two strobes (8'h12, 8'h34); second miso word = 8'h56.
- Underrun: no tx handshake before cs fall → tx_underrun pulses once, miso all zeros, rx still correct.
- Reset mid-frame: rstn=0 after 4 bits → no rx_valid, outputs at reset values, tx_ready=1. A following clean frame with 8'hFF yields rx_data=8'hFF.
- Idle tristate: cs=1 → miso=z. spi_clk toggling with cs high → no rx_valid, busy=0.
